// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits, odd parity, stop, acknowledge.
// Define PS2_HOST_TX_ACK_CHECK_EN to treat a high acknowledge bit as a transfer error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);
    localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam logic [InhW-1:0]  InhLast  = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {StIdle, StRts, StStart, StData, StAck, StWaitRelease} state_e;

    state_e           state_q, state_d;
    logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic             filt_q, filt_d, fall_q, fall_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [InhW-1:0]  inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic             err_flag_q, err_flag_d;
    logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic             idle_q, idle_d, done_q, done_d, err_tick_q, err_tick_d;

    // A new clock level is accepted only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                filt_d = clk_s2_q;
                fall_d = ~clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_flag_d = err_flag_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        idle_d     = idle_q;
        done_d     = 1'b0;
        err_tick_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr) begin
                    frame_d    = {1'b1, ~^din, din};
                    inh_cnt_d  = '0;
                    err_flag_d = 1'b0;
                    clk_oe_d   = 1'b1;
                    idle_d     = 1'b0;
                    state_d    = StRts;
                end
            end
            StRts: begin
                if (inh_cnt_q == InhLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = StStart;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            StStart: begin
                if (fall_q) begin
                    data_oe_d = ~frame_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = StData;
                end
            end
            StData: begin
                if (fall_q) begin
                    data_oe_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (fall_q) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                    if (data_s2_q) begin
                        err_tick_d = 1'b1;
                        err_flag_d = 1'b1;
                    end
`endif
                    state_d = StWaitRelease;
                end
            end
            StWaitRelease: begin
                if (filt_q && data_s2_q) begin
                    done_d  = ~err_flag_q;
                    idle_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Watchdog between device clock falls; overrides the state decode above.
        if (state_q inside {StStart, StData, StAck}) begin
            if (fall_q) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == ToLast) begin
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                err_tick_d = 1'b1;
                idle_d     = 1'b1;
                state_d    = StIdle;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            err_flag_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            idle_q     <= 1'b1;
            done_q     <= 1'b0;
            err_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_flag_q <= err_flag_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            err_tick_q <= err_tick_d;
        end
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign tx_err_tick  = err_tick_q;

endmodule
